// File: rtl/reaction_timebase_if.sv
// Request/status bundle between the reaction-game controller and its timebase.
// The master drives the requests and reads back the done/late flags and the display.
interface reaction_timebase_if;
  logic        start_rwait;
  logic        start_wait5;
  logic        time_clr;
  logic        time_en;
  logic        rs_en;
  logic        rwait_done;
  logic        wait5_done;
  logic        time_late;
  logic [15:0] disp_bcd;

  modport master (
    output start_rwait, start_wait5, time_clr, time_en, rs_en,
    input  rwait_done, wait5_done, time_late, disp_bcd
  );

  modport slave (
    input  start_rwait, start_wait5, time_clr, time_en, rs_en,
    output rwait_done, wait5_done, time_late, disp_bcd
  );
endinterface

// File: rtl/reaction_timebase.sv
// Millisecond timebase for a reaction-time game: a 1 ms prescaler, a random wait, a fixed
// hold wait, and a saturating reaction counter with a BCD mirror for the display.
module reaction_timebase #(
  parameter int CLK_HZ       = 100_000_000,
  parameter int RWAIT_MIN_MS = 1000,
  parameter int WAIT5_MS     = 5000,
  parameter int LATE_MS      = 1000
) (
  input  logic               clk,
  input  logic               rst_n,
  reaction_timebase_if.slave bus
);

  localparam int              TICK_DIV   = CLK_HZ / 1000;
  localparam int              PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [15:0]     LFSR_SEED  = 16'hACE1;
  localparam logic [13:0]     RT_MAX     = 14'd9999;
  localparam logic [13:0]     LATE_VAL   = 14'(LATE_MS);
  localparam logic [15:0]     RWAIT_MIN  = 16'(RWAIT_MIN_MS);
  localparam logic [15:0]     WAIT5_VAL  = 16'(WAIT5_MS);

  // Both waits share one behaviour; only the target source differs.
  typedef struct packed {
    logic        start_q;
    logic        done;
    logic [15:0] cnt;
    logic [15:0] target;
  } wait_t;

  logic [PW-1:0] presc_q, presc_d;
  logic          tick;
  logic [15:0]   lfsr_q, lfsr_d;
  wait_t         rw_q, rw_d, w5_q, w5_d;
  logic [13:0]   rt_q, rt_d;
  logic [15:0]   bcd_q, bcd_d;
  logic          late_q, late_d;

  function automatic wait_t wait_next(wait_t cur, logic start, logic tick_in,
                                      logic [15:0] new_target);
    wait_t nxt;
    nxt         = cur;
    nxt.start_q = start;
    if (!start) begin
      nxt.cnt  = '0;
      nxt.done = 1'b0;
    end else if (!cur.start_q) begin
      // A rising request swallows a coincident tick so the wait always starts from zero.
      nxt.target = new_target;
      nxt.cnt    = '0;
      nxt.done   = 1'b0;
    end else if (cur.cnt == cur.target) begin
      nxt.done = 1'b1;
    end else if (tick_in) begin
      nxt.cnt = cur.cnt + 16'd1;
    end
    return nxt;
  endfunction

  function automatic logic [15:0] bcd_inc(logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign tick = (presc_q == PRESC_LAST);

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    presc_d = bus.time_clr ? '0 : (tick ? '0 : presc_q + PW'(1));
    lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    rw_d    = wait_next(rw_q, bus.start_rwait, tick, RWAIT_MIN + {4'd0, lfsr_q[11:0]});
    w5_d    = wait_next(w5_q, bus.start_wait5, tick, WAIT5_VAL);
    rt_d    = rt_q;
    bcd_d   = bcd_q;
    late_d  = late_q;
    if (bus.time_clr) begin
      rt_d   = '0;
      bcd_d  = '0;
      late_d = 1'b0;
    end else begin
      if (bus.time_en && tick && (rt_q != RT_MAX)) begin
        rt_d  = rt_q + 14'd1;
        bcd_d = bcd_inc(bcd_q);
      end
      if (rt_q >= LATE_VAL) late_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      lfsr_q  <= LFSR_SEED;
      rw_q    <= '0;
      w5_q    <= '0;
      rt_q    <= '0;
      bcd_q   <= '0;
      late_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      lfsr_q  <= lfsr_d;
      rw_q    <= rw_d;
      w5_q    <= w5_d;
      rt_q    <= rt_d;
      bcd_q   <= bcd_d;
      late_q  <= late_d;
    end
  end

  assign bus.rwait_done = rw_q.done;
  assign bus.wait5_done = w5_q.done;
  assign bus.time_late  = late_q;
  assign bus.disp_bcd   = bus.rs_en ? bcd_q : 16'h0000;

endmodule

// File: tb/tb_reaction_timebase.sv
// Self-checking bench for reaction_timebase: directed scenarios plus randomized requests,
// all compared every cycle against a millisecond-level reference model.
module tb_reaction_timebase;

  localparam int CLK_HZ = 4000;
  localparam int TDIV   = CLK_HZ / 1000;
  localparam int RMIN   = 10;
  localparam int W5     = 20;
  localparam int LATE   = 30;

  logic clk = 1'b0;
  logic rst_n;

  reaction_timebase_if bus ();

  reaction_timebase #(
    .CLK_HZ      (CLK_HZ),
    .RWAIT_MIN_MS(RMIN),
    .WAIT5_MS    (W5),
    .LATE_MS     (LATE)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: ms phase, random source, per-wait tick counts, reaction time in ms.
  int          m_phase;
  logic [15:0] m_lfsr;
  bit          w_prev[2];
  bit          w_done[2];
  int          w_ticks[2];
  int          w_target[2];
  int          m_rt;
  bit          m_late;

  task automatic model_reset();
    m_phase = 0;
    m_lfsr  = 16'hACE1;
    m_rt    = 0;
    m_late  = 0;
    for (int k = 0; k < 2; k++) begin
      w_prev[k]   = 0;
      w_done[k]   = 0;
      w_ticks[k]  = 0;
      w_target[k] = 0;
    end
  endtask

  task automatic wait_model(input int k, input bit start, input bit tick, input int tgt);
    if (!start) begin
      w_ticks[k] = 0;
      w_done[k]  = 0;
    end else if (!w_prev[k]) begin
      w_target[k] = tgt;
      w_ticks[k]  = 0;
      w_done[k]   = 0;
    end else begin
      w_done[k] = (w_ticks[k] >= w_target[k]);
      if (tick && w_ticks[k] < w_target[k]) w_ticks[k]++;
    end
    w_prev[k] = start;
  endtask

  task automatic model_step();
    bit tick;
    tick = (m_phase == TDIV - 1);
    wait_model(0, bus.start_rwait, tick, RMIN + int'(m_lfsr[11:0]));
    wait_model(1, bus.start_wait5, tick, W5);
    if (bus.time_clr) begin
      m_rt   = 0;
      m_late = 0;
    end else begin
      if (m_rt >= LATE) m_late = 1;
      if (bus.time_en && tick && m_rt < 9999) m_rt++;
    end
    m_phase = bus.time_clr ? 0 : (m_phase + 1) % TDIV;
    m_lfsr  = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  int rw_rises = 0;
  bit last_rwd = 0;

  task automatic compare_all();
    check("rwait_done", bus.rwait_done, w_done[0]);
    check("wait5_done", bus.wait5_done, w_done[1]);
    check("time_late", bus.time_late, m_late);
    check("disp_bcd", bus.disp_bcd, bus.rs_en ? to_bcd(m_rt) : 16'h0000);
    if (bus.rwait_done && !last_rwd) rw_rises++;
    last_rwd = bus.rwait_done;
  endtask

  // Called at a falling edge: advance the model with the current inputs, clock once, compare.
  task automatic step();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic set_in(input bit rw, input bit w5, input bit clr, input bit en, input bit rs);
    bus.start_rwait = rw;
    bus.start_wait5 = w5;
    bus.time_clr    = clr;
    bus.time_en     = en;
    bus.rs_en       = rs;
  endtask

  int rw_left;
  int w5_left;
  int first_done;

  initial begin
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 1);
    model_reset();
    #1;
    check("rst_rwait_done", bus.rwait_done, 1'b0);
    check("rst_wait5_done", bus.wait5_done, 1'b0);
    check("rst_time_late", bus.time_late, 1'b0);
    check("rst_disp", bus.disp_bcd, 16'h0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reaction path: clear, count 123 ms, freeze, show.
    set_in(0, 0, 1, 0, 1);
    step();
    set_in(0, 0, 0, 1, 1);
    repeat (123 * TDIV) step();
    set_in(0, 0, 0, 0, 1);
    step();
    check("result_0123", bus.disp_bcd, 16'h0123);
    check("result_late", bus.time_late, 1'b1);
    bus.rs_en = 1'b0;
    #1;
    check("result_rs_off", bus.disp_bcd, 16'h0000);

    // Late flag lands one cycle after the count reaches 30.
    set_in(0, 0, 1, 0, 1);
    step();
    check("clr_late", bus.time_late, 1'b0);
    set_in(0, 0, 0, 1, 1);
    repeat (LATE * TDIV) step();
    check("late_count30", bus.disp_bcd, 16'h0030);
    check("late_not_yet", bus.time_late, 1'b0);
    set_in(0, 0, 0, 0, 1);
    step();
    check("late_set", bus.time_late, 1'b1);

    // Fixed wait: a 10 ms pulse never completes, a 25 ms hold completes near 20 ms.
    set_in(0, 1, 0, 0, 1);
    repeat (10 * TDIV) step();
    set_in(0, 0, 0, 0, 1);
    repeat (8) step();
    check("w5_short_pulse", bus.wait5_done, 1'b0);
    set_in(0, 1, 0, 0, 1);
    first_done = -1;
    for (int i = 1; i <= 25 * TDIV; i++) begin
      step();
      if (first_done < 0 && bus.wait5_done) first_done = i;
    end
    check("w5_done_window", (first_done >= W5 * TDIV - TDIV) && (first_done <= W5 * TDIV + 2), 1'b1);
    set_in(0, 0, 0, 0, 1);
    step();
    check("w5_drop", bus.wait5_done, 1'b0);

    // Mixed random phase: random clears, enables, display and wait requests.
    for (int i = 0; i < 3000; i++) begin
      set_in($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 199) == 0,
             $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0);
      step();
    end

    // Long run through saturation with randomized overlapping waits.
    set_in(0, 0, 1, 0, 1);
    step();
    rw_left = 1;
    w5_left = 1;
    for (int i = 0; i < 10050 * TDIV; i++) begin
      bus.time_clr = 1'b0;
      bus.time_en  = 1'b1;
      bus.rs_en    = ($urandom_range(0, 15) != 0);
      if (rw_left > 0) rw_left--;
      if (rw_left == 0) begin
        if (bus.start_rwait) begin
          bus.start_rwait = 1'b0;
          rw_left = $urandom_range(1, 8);
        end else begin
          bus.start_rwait = 1'b1;
          rw_left = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 200) : 20000;
        end
      end
      if (bus.start_rwait && w_done[0] && rw_left > 40) rw_left = $urandom_range(1, 40);
      if (w5_left > 0) w5_left--;
      if (w5_left == 0) begin
        bus.start_wait5 = ~bus.start_wait5;
        w5_left = bus.start_wait5 ? $urandom_range(1, 120) : $urandom_range(1, 10);
      end
      step();
    end
    bus.rs_en = 1'b1;
    #1;
    check("saturated_9999", bus.disp_bcd, 16'h9999);
    check("rwait_seen", rw_rises > 0, 1'b1);
    set_in(0, 0, 1, 1, 1);
    step();
    check("sat_clr_disp", bus.disp_bcd, 16'h0000);
    check("sat_clr_late", bus.time_late, 1'b0);

    // Asynchronous reset mid-count with both requests held across release.
    set_in(1, 1, 0, 1, 1);
    repeat (150) step();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_rwait_done", bus.rwait_done, 1'b0);
    check("arst_wait5_done", bus.wait5_done, 1'b0);
    check("arst_time_late", bus.time_late, 1'b0);
    check("arst_disp", bus.disp_bcd, 16'h0000);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 200; i++) begin
      step();
      if (i == TDIV - 1) check("first_tick_early", bus.disp_bcd, 16'h0000);
      if (i == TDIV) check("first_tick", bus.disp_bcd, 16'h0001);
    end
    check("rel_wait5_done", bus.wait5_done, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
